// File: rtl/top_level_pkg.sv
// top_level_pkg: shared states, memory map, register indices and step counts
package top_level_pkg;
   typedef enum logic [1:0] {LOAD, MUL, STORE, HALT} state_t;
   localparam logic [7:0] A_HI = 8'd1, A_LO = 8'd2, B_HI = 8'd3, B_LO = 8'd4, P_BASE = 8'd5;
   localparam logic [3:0] R_AHI = 4'd1, R_ALO = 4'd2, R_P3 = 4'd5, R_P2 = 4'd6, R_P1 = 4'd7, R_P0 = 4'd8, R_CNT = 4'd9;
   localparam logic [7:0] LOAD_STEPS = 8'd4, MUL_STEPS = 8'd16, STORE_STEPS = 8'd4;
endpackage

// File: rtl/top_level_data_mem.sv
// top_level_data_mem: 256x8 data memory, async read, sync write
module top_level_data_mem (
   input  logic       CLK,
   input  logic       we,
   input  logic [7:0] addr,
   input  logic [7:0] wd,
   output logic [7:0] rd
);
   logic [7:0] core [0:255];
   always_ff @(posedge CLK)
      if (we) core[addr] <= wd;
   assign rd = core[addr];
endmodule

// File: rtl/top_level_reg_file.sv
// top_level_reg_file: 16x8 registers, two read ports, byte write plus wide accumulator/counter paths
module top_level_reg_file
   import top_level_pkg::*;
(
   input  logic        CLK,
   input  logic        we,
   input  logic [3:0]  wa,
   input  logic [7:0]  wd,
   input  logic [3:0]  ra1,
   input  logic [3:0]  ra2,
   output logic [7:0]  rd1,
   output logic [7:0]  rd2,
   input  logic        acc_we,
   input  logic [31:0] acc_wd,
   output logic [31:0] acc,
   input  logic        cnt_we,
   input  logic [7:0]  cnt_wd,
   output logic [7:0]  cnt
);
   logic [7:0] registers [0:15];
   always_ff @(posedge CLK) begin
      if (acc_we) begin
         registers[R_P3] <= acc_wd[31:24];
         registers[R_P2] <= acc_wd[23:16];
         registers[R_P1] <= acc_wd[15:8];
         registers[R_P0] <= acc_wd[7:0];
      end
      if (cnt_we) registers[R_CNT] <= cnt_wd;
      if (we) registers[wa] <= wd;
   end
   assign rd1 = registers[ra1];
   assign rd2 = registers[ra2];
   assign acc = {registers[R_P3], registers[R_P2], registers[R_P1], registers[R_P0]};
   assign cnt = registers[R_CNT];
endmodule

// File: rtl/top_level.sv
// top_level: shift-add 16x16 multiplier core sequencing LOAD/MUL/STORE over memory and register file
module top_level
   import top_level_pkg::*;
(
   input  logic CLK,
   input  logic start,
   output logic halt
);
   state_t state, state_nx;
   logic [7:0] PC, step, mem_addr, mem_rd, mem_wd, rd1, rd2, cnt, cnt_wd;
   logic [3:0] rf_wa;
   logic [31:0] acc, acc_wd;
   logic [16:0] sum;
   logic mem_we, rf_we, acc_we;
   top_level_data_mem data_mem (
      .CLK(CLK), .we(mem_we), .addr(mem_addr), .wd(mem_wd), .rd(mem_rd)
   );
   top_level_reg_file reg_file (
      .CLK(CLK), .we(rf_we), .wa(rf_wa), .wd(mem_rd), .ra1(R_AHI), .ra2(R_ALO),
      .rd1(rd1), .rd2(rd2), .acc_we(acc_we), .acc_wd(acc_wd), .acc(acc),
      .cnt_we(acc_we), .cnt_wd(cnt_wd), .cnt(cnt)
   );
   always_ff @(posedge CLK)
      if (start) begin
         state <= LOAD;
         PC <= '0;
      end else begin
         state <= state_nx;
         PC <= (state == HALT) ? PC : PC + 8'd1;
      end
   always_comb begin
      step = PC - (LOAD_STEPS + MUL_STEPS);
      mem_addr = (state == STORE) ? P_BASE + step : A_HI + PC;
      mem_we = !start && state == STORE;
      mem_wd = acc[{~step[1:0], 3'b000} +: 8];
      rf_we = !start && state == LOAD;
      rf_wa = PC[1] ? (PC[0] ? R_P0 : R_P1) : (PC[0] ? R_ALO : R_AHI);
      sum = {1'b0, acc[31:16]} + (acc[0] ? {1'b0, rd1, rd2} : 17'd0);
      acc_we = !start && (state == MUL || (state == LOAD && PC == 8'd0));
      acc_wd = (state == MUL) ? {sum, acc[15:1]} : {16'd0, acc[15:0]};
      cnt_wd = (state == MUL) ? cnt + 8'd1 : 8'd0;
      state_nx = (state == LOAD && PC == LOAD_STEPS - 8'd1) ? MUL :
                 (state == MUL && cnt == MUL_STEPS - 8'd1) ? STORE :
                 (state == STORE && PC == LOAD_STEPS + MUL_STEPS + STORE_STEPS - 8'd1) ? HALT : state;
   end
   assign halt = state == HALT;
endmodule

// File: tb/tb_top_level.sv
// tb_top_level: randomized self-checking bench against an arithmetic model of the multiplier core
module tb_top_level;
   logic CLK = 0, start = 1, halt;
   int vectors = 0, miscompares = 0, n = 0;
   bit chk_en = 0;
   logic [7:0] mmem [256];
   logic [7:0] mreg [16];
   logic [31:0] prod = 0;

   top_level dut (.CLK(CLK), .start(start), .halt(halt));

   always #5 CLK = ~CLK;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // model: n counts edges since release; product bytes land at edges 20..23, big-endian
   always @(posedge CLK) begin
      if (start) begin
         n = 0;
         chk_en = 1;
      end else begin
         if (n >= 20 && n < 24) mmem[n - 15] = prod[8 * (23 - n) +: 8];
         if (n < 24) n++;
      end
   end

   always @(negedge CLK)
      if (chk_en) begin
         check("halt", halt, n == 24);
         check("pc", dut.PC, n[7:0]);
         for (int i = 5; i < 9; i++) check("p_byte", dut.data_mem.core[i], mmem[i]);
      end

   task automatic preload(logic [15:0] a, logic [15:0] b, int mode);
      for (int i = 0; i < 256; i++) begin
         logic [7:0] v;
         v = (mode == 0) ? 8'h00 : (mode == 1) ? ((i == 0) ? 8'hAA : 8'h55) : 8'($urandom);
         v = (i == 1) ? a[15:8] : (i == 2) ? a[7:0] : (i == 3) ? b[15:8] : (i == 4) ? b[7:0] : v;
         mmem[i] = v;
         dut.data_mem.core[i] = v;
      end
      for (int i = 0; i < 16; i++) begin
         mreg[i] = 8'($urandom);
         dut.reg_file.registers[i] = mreg[i];
      end
      prod = {16'h0, a} * {16'h0, b};
   endtask

   task automatic run(logic [15:0] a, logic [15:0] b, int mode, int restart_at);
      int k;
      @(negedge CLK);
      start = 1;
      preload(a, b, mode);
      @(negedge CLK);
      start = 0;
      if (restart_at > 0) begin
         repeat (restart_at) @(negedge CLK);
         start = 1;
         @(negedge CLK);
         start = 0;
      end
      k = 0;
      while (!halt && k < 40) begin
         @(negedge CLK);
         k++;
      end
      check("halt_latency", k, 24);
      repeat (3) @(negedge CLK);
      for (int i = 0; i < 256; i++) check("mem_final", dut.data_mem.core[i], mmem[i]);
      mreg[1] = a[15:8];
      mreg[2] = a[7:0];
      for (int i = 0; i < 4; i++) mreg[5 + i] = prod[8 * (3 - i) +: 8];
      mreg[9] = 8'd16;
      for (int i = 0; i < 16; i++) check("reg_final", dut.reg_file.registers[i], mreg[i]);
   endtask

   function automatic logic [31:0] p_mem();
      return {dut.data_mem.core[5], dut.data_mem.core[6], dut.data_mem.core[7], dut.data_mem.core[8]};
   endfunction

   initial begin
      run(16'h03FF, 16'hFFFB, 0, 0);
      check("lit_03ff_fffb", p_mem(), 32'h03FEEC05);
      run(16'hFFFF, 16'hFFFF, 2, 0);
      check("lit_ffff_ffff", p_mem(), 32'hFFFE0001);
      run(16'h0000, 16'h1234, 0, 0);
      check("lit_0_1234", p_mem(), 32'h00000000);
      run(16'h0001, 16'h1234, 1, 0);
      check("lit_1_1234", p_mem(), 32'h00001234);
      check("lit_core0", dut.data_mem.core[0], 8'hAA);
      check("lit_core9", dut.data_mem.core[9], 8'h55);
      run(16'($urandom), 16'($urandom), 2, 10);
      for (int t = 0; t < 6; t++) run(16'($urandom), 16'($urandom), 2, 0);
      @(negedge CLK);
      start = 1;
      preload(16'h1357, 16'h2468, 1);
      repeat (50) @(negedge CLK);
      check("hold_halt", halt, 1'b0);
      check("hold_pc", dut.PC, 8'd0);
      for (int i = 0; i < 256; i++) check("hold_mem", dut.data_mem.core[i], mmem[i]);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
